// File: rtl/tpu_iss_buf.sv
// ----------------------------------------------------------------------------
// tpu_iss_buf : in-order issue buffer between the TPU line and execute stage
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tpu_iss_buf #(
  parameter int TPU_INST_WIDTH   = 28,
  parameter int ISQ_IDX_BITS_NUM = 2,
  parameter int DEPTH            = 4,
  parameter int CNT_W            = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tpu_inst_rdy,
  input  logic [TPU_INST_WIDTH-1:0]   tpu_inst,
  output logic                        tpu_ack,
  input  logic                        flush,
  input  logic                        iss_rdy,
  output logic                        iss_vld,
  output logic [TPU_INST_WIDTH-1:0]   iss_inst,
  output logic                        iss_free_vld,
  output logic [ISQ_IDX_BITS_NUM-1:0] iss_free_idx,
  output logic [CNT_W-1:0]            buf_cnt,
  output logic                        buf_full
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TPU_INST_WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        free_vld_q, free_vld_d;
  logic [ISQ_IDX_BITS_NUM-1:0] free_idx_q, free_idx_d;
  logic                        pop;
  logic                        push;

  assign iss_vld  = (cnt_q != '0);
  assign buf_full = (cnt_q == FULL_CNT);
  assign buf_cnt  = cnt_q;
  assign pop      = iss_vld & iss_rdy;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign push     = tpu_inst_rdy & ~flush & (~buf_full | pop);
  assign tpu_ack  = push;

  // Storage is never exposed while empty.
  assign iss_inst     = iss_vld ? mem_q[rd_ptr_q] : '0;
  assign iss_free_vld = free_vld_q;
  assign iss_free_idx = free_idx_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    free_vld_d = pop;
    free_idx_d = free_idx_q;

    if (pop) begin
      free_idx_d = iss_inst[TPU_INST_WIDTH-1 -: ISQ_IDX_BITS_NUM];
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      free_vld_q <= 1'b0;
      free_idx_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      free_vld_q <= free_vld_d;
      free_idx_q <= free_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tpu_inst;
  end

endmodule

`default_nettype wire

// File: tb/tb_tpu_iss_buf.sv
// ----------------------------------------------------------------------------
// tb_tpu_iss_buf : scoreboard bench for the TPU issue buffer
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tpu_iss_buf;

  localparam int W  = 28;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tpu_inst_rdy;
  logic [W-1:0]  tpu_inst;
  logic          tpu_ack;
  logic          flush;
  logic          iss_rdy;
  logic          iss_vld;
  logic [W-1:0]  iss_inst;
  logic          iss_free_vld;
  logic [IW-1:0] iss_free_idx;
  logic [CW-1:0] buf_cnt;
  logic          buf_full;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_word;
  logic [IW-1:0] exp_idx;

  tpu_iss_buf #(
    .TPU_INST_WIDTH  (W),
    .ISQ_IDX_BITS_NUM(IW),
    .DEPTH           (4),
    .CNT_W           (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tpu_inst_rdy(tpu_inst_rdy),
    .tpu_inst    (tpu_inst),
    .tpu_ack     (tpu_ack),
    .flush       (flush),
    .iss_rdy     (iss_rdy),
    .iss_vld     (iss_vld),
    .iss_inst    (iss_inst),
    .iss_free_vld(iss_free_vld),
    .iss_free_idx(iss_free_idx),
    .buf_cnt     (buf_cnt),
    .buf_full    (buf_full)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tpu_inst_rdy = 1'b0; tpu_inst = '0; flush = 1'b0; iss_rdy = 1'b0;
    tick();
    total++; if (iss_vld !== 1'b0)     begin bad++; $display("FAIL reset_vld got=%b exp=0", iss_vld); end
    total++; if (buf_cnt !== 3'd0)     begin bad++; $display("FAIL reset_cnt got=%0d exp=0", buf_cnt); end
    total++; if (tpu_ack !== 1'b0)     begin bad++; $display("FAIL reset_ack got=%b exp=0", tpu_ack); end
    total++; if (iss_free_vld !== 1'b0) begin bad++; $display("FAIL reset_free got=%b exp=0", iss_free_vld); end
    total++; if (iss_inst !== '0 || buf_full !== 1'b0)
      begin bad++; $display("FAIL reset_inst got=%h/%b exp=0/0", iss_inst, buf_full); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    tpu_inst = 28'h4A5B3C1; tpu_inst_rdy = 1'b1; iss_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (tpu_ack !== (c == 0)) begin bad++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, tpu_ack, (c == 0)); end
      if (tpu_ack) exp_q.push_back(tpu_inst);
      tick();
      if (c == 0) tpu_inst_rdy = 1'b0;
    end
    total++; if (buf_cnt !== 3'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", buf_cnt); end
    total++; if (iss_inst !== 28'h4A5B3C1 || iss_vld !== 1'b1)
      begin bad++; $display("FAIL single_inst got=%h vld=%b exp=4a5b3c1 vld=1", iss_inst, iss_vld); end
    iss_rdy = 1'b1;
    #1;
    exp_word = exp_q.pop_front();
    total++; if (iss_inst !== exp_word) begin bad++; $display("FAIL single_pop got=%h exp=%h", iss_inst, exp_word); end
    tick();
    iss_rdy = 1'b0;
    total++; if (iss_free_vld !== 1'b1 || iss_free_idx !== 2'b01)
      begin bad++; $display("FAIL single_free got=%b/%b exp=1/01", iss_free_vld, iss_free_idx); end
    total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL single_cnt0 got=%0d exp=0", buf_cnt); end
    tick();
    total++; if (iss_free_vld !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", iss_free_vld); end
  endtask

  task automatic test_fill_block();
    int budget;
    for (int i = 0; i < 4; i++) begin
      tpu_inst = {2'(i), 26'($urandom)}; tpu_inst_rdy = 1'b1;
      #1;
      total++; if (tpu_ack !== 1'b1) begin bad++; $display("FAIL fill_ack i=%0d got=%b exp=1", i, tpu_ack); end
      exp_q.push_back(tpu_inst);
      tick();
    end
    tpu_inst_rdy = 1'b0;
    total++; if (buf_full !== 1'b1 || buf_cnt !== 3'd4)
      begin bad++; $display("FAIL fill_full got=%b/%0d exp=1/4", buf_full, buf_cnt); end
    tpu_inst = {2'b10, 26'h2BEEF01}; tpu_inst_rdy = 1'b1;
    #1;
    total++; if (tpu_ack !== 1'b0) begin bad++; $display("FAIL fill_block_ack got=%b exp=0", tpu_ack); end
    tick();
    total++; if (buf_cnt !== 3'd4) begin bad++; $display("FAIL fill_block_cnt got=%0d exp=4", buf_cnt); end
    iss_rdy = 1'b1;
    #1;
    total++; if (tpu_ack !== 1'b1) begin bad++; $display("FAIL fill_swap_ack got=%b exp=1", tpu_ack); end
    exp_word = exp_q.pop_front();
    total++; if (iss_inst !== exp_word) begin bad++; $display("FAIL fill_swap_pop got=%h exp=%h", iss_inst, exp_word); end
    exp_idx = exp_word[W-1 -: IW];
    if (tpu_ack) exp_q.push_back(tpu_inst);
    tick();
    tpu_inst_rdy = 1'b0;
    total++; if (buf_cnt !== 3'd4) begin bad++; $display("FAIL fill_swap_cnt got=%0d exp=4", buf_cnt); end
    total++; if (iss_free_vld !== 1'b1 || iss_free_idx !== exp_idx)
      begin bad++; $display("FAIL fill_swap_free got=%b/%b exp=1/%b", iss_free_vld, iss_free_idx, exp_idx); end
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      #1;
      exp_word = exp_q.pop_front();
      exp_idx  = exp_word[W-1 -: IW];
      total++; if (iss_vld !== 1'b1 || iss_inst !== exp_word)
        begin bad++; $display("FAIL fill_order got=%h vld=%b exp=%h", iss_inst, iss_vld, exp_word); end
      tick();
      total++; if (iss_free_vld !== 1'b1 || iss_free_idx !== exp_idx)
        begin bad++; $display("FAIL fill_free got=%b/%b exp=1/%b", iss_free_vld, iss_free_idx, exp_idx); end
      budget++;
    end
    iss_rdy = 1'b0;
    total++; if (buf_cnt !== 3'd0 || exp_q.size() != 0)
      begin bad++; $display("FAIL fill_drain got=%0d left=%0d exp=0/0", buf_cnt, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    tpu_inst = {2'b11, 26'h0000100}; tpu_inst_rdy = 1'b1; iss_rdy = 1'b0;
    #1;
    if (tpu_ack) exp_q.push_back(tpu_inst);
    tick();
    iss_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tpu_inst = {2'(i + 1), 26'($urandom)};
      #1;
      total++; if (tpu_ack !== 1'b1) begin bad++; $display("FAIL wrap_ack i=%0d got=%b exp=1", i, tpu_ack); end
      exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      exp_idx  = exp_word[W-1 -: IW];
      total++; if (iss_inst !== exp_word) begin bad++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, iss_inst, exp_word); end
      if (tpu_ack) exp_q.push_back(tpu_inst);
      tick();
      total++; if (buf_cnt !== 3'd1 || iss_free_vld !== 1'b1 || iss_free_idx !== exp_idx)
        begin bad++; $display("FAIL wrap_state i=%0d got=%0d/%b/%b exp=1/1/%b", i, buf_cnt, iss_free_vld, iss_free_idx, exp_idx); end
    end
    tpu_inst_rdy = 1'b0;
    #1;
    exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    total++; if (iss_inst !== exp_word) begin bad++; $display("FAIL wrap_last got=%h exp=%h", iss_inst, exp_word); end
    tick();
    iss_rdy = 1'b0;
    total++; if (buf_cnt !== 3'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", buf_cnt); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      tpu_inst = {2'(3 - i), 26'($urandom)}; tpu_inst_rdy = 1'b1;
      #1;
      if (tpu_ack) exp_q.push_back(tpu_inst);
      tick();
    end
    total++; if (buf_cnt !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", buf_cnt); end
    tpu_inst = 28'hABCDEF0; flush = 1'b1; iss_rdy = 1'b1;
    #1;
    total++; if (tpu_ack !== 1'b0) begin bad++; $display("FAIL flush_ack got=%b exp=0", tpu_ack); end
    exp_word = exp_q[0];
    exp_idx  = exp_word[W-1 -: IW];
    total++; if (iss_inst !== exp_word) begin bad++; $display("FAIL flush_head got=%h exp=%h", iss_inst, exp_word); end
    tick();
    flush = 1'b0; tpu_inst_rdy = 1'b0; iss_rdy = 1'b0;
    exp_q.delete();
    total++; if (buf_cnt !== 3'd0 || iss_vld !== 1'b0)
      begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", buf_cnt, iss_vld); end
    total++; if (iss_free_vld !== 1'b1 || iss_free_idx !== exp_idx)
      begin bad++; $display("FAIL flush_free got=%b/%b exp=1/%b", iss_free_vld, iss_free_idx, exp_idx); end
    tick();
    total++; if (iss_free_vld !== 1'b0) begin bad++; $display("FAIL flush_pulse got=%b exp=0", iss_free_vld); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      tpu_inst = {2'(i), 26'($urandom)}; tpu_inst_rdy = 1'b1;
      #1;
      if (tpu_ack) exp_q.push_back(tpu_inst);
      tick();
    end
    tpu_inst_rdy = 1'b0; iss_rdy = 1'b1;
    tick();
    iss_rdy = 1'b0;
    total++; if (buf_cnt !== 3'd2 || iss_free_vld !== 1'b1)
      begin bad++; $display("FAIL areset_pre got=%0d/%b exp=2/1", buf_cnt, iss_free_vld); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (iss_vld !== 1'b0 || buf_cnt !== 3'd0 || iss_free_vld !== 1'b0)
      begin bad++; $display("FAIL areset_now got=%b/%0d/%b exp=0/0/0", iss_vld, buf_cnt, iss_free_vld); end
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    total++; if (iss_vld !== 1'b0 || buf_cnt !== 3'd0)
      begin bad++; $display("FAIL areset_after got=%b/%0d exp=0/0", iss_vld, buf_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_block();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
